pkts_from_ddr_sm: RTL and testbench
===================================

PKTS_FROM_DDR_SM -- requirements
Module: pkts_from_ddr_sm

Interface
REQ-001 SHALL have parameter AVL_ADDR_WIDTH, default 29, Avalon word address width.
REQ-002 SHALL have parameter AVL_DATA_WIDTH, default 512, Avalon data width.
REQ-003 SHALL have parameter FRAME_ID_WIDTH, default 32, frame identifier width.
REQ-004 SHALL have parameter BIN_ADDR_WIDTH, default 8, frame-buffer bin index width.
REQ-005 SHALL have parameter FRAME_OFFSET_WIDTH, default 5, log2 of max beats per frame.
REQ-006 SHALL have parameter RSP_FIFO_DEPTH, default 8, read-response buffer entries, power of two.
REQ-007 SHALL have localparam WIDTH_PKT = AVL_DATA_WIDTH+2+FRAME_ID_WIDTH.
REQ-008 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have ports: req_valid in 1, req_ready out 1, req_bin in BIN_ADDR_WIDTH, req_len in FRAME_OFFSET_WIDTH+1 (beats), req_frame_id in FRAME_ID_WIDTH.
REQ-010 SHALL have Avalon master ports: avl_address out AVL_ADDR_WIDTH, avl_read out 1, avl_write out 1, avl_writedata out AVL_DATA_WIDTH, avl_byteenable out AVL_DATA_WIDTH/8, avl_waitrequest in 1, avl_readdata in AVL_DATA_WIDTH, avl_readdatavalid in 1.
REQ-011 SHALL have NoC ports: noc_data_out out WIDTH_PKT, noc_valid_out out 4, noc_sop_out out 4, noc_eop_out out 4, noc_ready_in in 1.

Function
REQ-012 SHALL tie avl_write=0, avl_writedata=0, avl_byteenable all ones.
REQ-013 SHALL implement states IDLE, ISSUE, DRAIN; req_ready=1 only in IDLE.
REQ-014 IDLE: on req_valid with req_len!=0, latch bin/len/frame_id, go ISSUE next cycle; req_len=0 accepted and dropped, stay IDLE.
REQ-015 req_len > 2^FRAME_OFFSET_WIDTH SHALL be clamped to 2^FRAME_OFFSET_WIDTH.
REQ-016 avl_address SHALL equal {bin, beat_index} zero-extended to AVL_ADDR_WIDTH, beat_index 0..len-1.
REQ-017 ISSUE: avl_read asserted only when outstanding+fifo_count < RSP_FIFO_DEPTH; address/read held stable while avl_waitrequest=1; beat_index advances on avl_read && !avl_waitrequest.
REQ-018 After last read accepted, SHALL go DRAIN; DRAIN returns to IDLE the cycle after the eop beat is accepted (valid && noc_ready_in).
REQ-019 outstanding SHALL increment on accepted read, decrement on avl_readdatavalid; simultaneous events leave it unchanged; readdatavalid with outstanding=0 SHALL be ignored.
REQ-020 Every accepted avl_readdatavalid beat SHALL be pushed to the response FIFO; FIFO never overflows by REQ-017.
REQ-021 FIFO head SHALL drive noc_data_out = {frame_id, sop, eop, readdata} (readdata in [AVL_DATA_WIDTH-1:0]); noc_valid_out=4'b1111 when non-empty, else 0.
REQ-022 First beat of frame: noc_sop_out=4'b0001; last beat: noc_eop_out=4'b1000; single-beat frame asserts both; else 0.
REQ-023 Head popped on noc_valid_out!=0 && noc_ready_in; data/flags held stable while noc_ready_in=0; simultaneous push and pop on full or empty FIFO SHALL be legal.
REQ-024 Minimum latency: req accept at cycle T -> avl_read at T+1; readdatavalid at cycle R -> noc_valid_out at R+1.

Reset
REQ-025 rst SHALL asynchronously force IDLE, clear counters, pointers and outstanding; all outputs 0 except req_ready=1 and avl_byteenable all ones.
REQ-026 Reset mid-frame SHALL abandon the frame; stray readdatavalid after reset ignored per REQ-019.

Configuration
REQ-027 With DDR_RD_STATS_EN defined, SHALL add outputs stat_frames out 32 (increments per eop accepted) and stat_beats out 32 (increments per beat accepted), both wrapping, reset to 0.
REQ-028 Without DDR_RD_STATS_EN, those ports and counters SHALL not exist; function otherwise identical.

Verification
REQ-029 req bin=3 len=4 id=0xA, waitrequest=0, readdatavalid 2 cycles after read, ready=1 -> addresses 0x60..0x63, 4 beats, sop on beat 0, eop on beat 3, id 0xA in all.
REQ-030 len=1 -> one beat with sop=4'b0001 and eop=4'b1000 together.
REQ-031 len=32, noc_ready_in=0 throughout -> exactly 8 reads issued then avl_read stays 0; releasing ready -> all 32 beats delivered in order.
REQ-032 waitrequest=1 for 5 cycles on 2nd read -> avl_address held at beat 1, no duplicate or skipped addresses.
REQ-033 len=0 then len=2 back-to-back -> first dropped, 2 beats out; with DDR_RD_STATS_EN stat_frames=1, stat_beats=2.
REQ-034 rst asserted after 2 of 6 beats issued -> outputs return to reset values immediately; late readdatavalid produces no output; next request completes correctly.

Source files
------------

// File: rtl/pkts_from_ddr_sm.sv
// pkts_from_ddr_sm: fetches one frame of beats from DDR through an Avalon-MM read master
// and forwards the beats as a NoC packet stream with sop/eop marking. A read is issued only
// when a response-buffer slot is already reserved for it, so the buffer never overflows.
// Build option: define DDR_RD_STATS_EN to add the stat_frames/stat_beats counters.
module pkts_from_ddr_sm #(
   parameter int unsigned AVL_ADDR_WIDTH     = 29,
   parameter int unsigned AVL_DATA_WIDTH     = 512,
   parameter int unsigned FRAME_ID_WIDTH     = 32,
   parameter int unsigned BIN_ADDR_WIDTH     = 8,
   parameter int unsigned FRAME_OFFSET_WIDTH = 5,
   parameter int unsigned RSP_FIFO_DEPTH     = 8,
   localparam int unsigned WIDTH_PKT         = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   // frame request
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [BIN_ADDR_WIDTH-1:0]     req_bin,
   input  logic [FRAME_OFFSET_WIDTH:0]   req_len,
   input  logic [FRAME_ID_WIDTH-1:0]     req_frame_id,
   // Avalon-MM master
   output logic [AVL_ADDR_WIDTH-1:0]     avl_address,
   output logic                          avl_read,
   output logic                          avl_write,
   output logic [AVL_DATA_WIDTH-1:0]     avl_writedata,
   output logic [AVL_DATA_WIDTH/8-1:0]   avl_byteenable,
   input  logic                          avl_waitrequest,
   input  logic [AVL_DATA_WIDTH-1:0]     avl_readdata,
   input  logic                          avl_readdatavalid,
   // NoC output
   output logic [WIDTH_PKT-1:0]          noc_data_out,
   output logic [3:0]                    noc_valid_out,
   output logic [3:0]                    noc_sop_out,
   output logic [3:0]                    noc_eop_out,
   input  logic                          noc_ready_in
`ifdef DDR_RD_STATS_EN
   ,
   output logic [31:0]                   stat_frames,
   output logic [31:0]                   stat_beats
`endif
);

   localparam int unsigned LEN_W = FRAME_OFFSET_WIDTH + 1;
   localparam int unsigned PTR_W = $clog2(RSP_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {FRAME_OFFSET_WIDTH{1'b0}}};
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(RSP_FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [BIN_ADDR_WIDTH-1:0] bin_q, bin_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic [FRAME_ID_WIDTH-1:0] frame_id_q, frame_id_d;
   logic [LEN_W-1:0]          rd_idx_q, rd_idx_d;
   logic [LEN_W-1:0]          rsp_idx_q, rsp_idx_d;
   logic [CNT_W-1:0]          outstanding_q, outstanding_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [WIDTH_PKT-1:0]      mem_q [RSP_FIFO_DEPTH];

   logic                      rd_accept;
   logic                      rsp_push;
   logic                      fifo_valid;
   logic                      fifo_pop;
   logic [CNT_W:0]            inflight;
   logic [WIDTH_PKT-1:0]      head;
   logic                      head_sop;
   logic                      head_eop;
   logic                      push_sop;
   logic                      push_eop;
   logic [WIDTH_PKT-1:0]      push_word;

   // Handshake decode and response-buffer head view
   always_comb begin
      inflight   = {1'b0, outstanding_q} + {1'b0, count_q};
      avl_read   = (state_q == ISSUE) && (inflight < DEPTH_C);
      rd_accept  = avl_read && !avl_waitrequest;
      // A response with nothing outstanding is a leftover from an abandoned frame
      rsp_push   = avl_readdatavalid && (outstanding_q != '0);
      fifo_valid = (count_q != '0);
      fifo_pop   = fifo_valid && noc_ready_in;
      head       = mem_q[rd_ptr_q];
      head_eop   = head[AVL_DATA_WIDTH];
      head_sop   = head[AVL_DATA_WIDTH+1];
      push_sop   = (rsp_idx_q == '0);
      push_eop   = (rsp_idx_q == len_q - LEN_W'(1));
      push_word  = {frame_id_q, push_sop, push_eop, avl_readdata};
   end

   // Output drive; NoC outputs are forced to zero while the buffer is empty
   always_comb begin
      req_ready      = (state_q == IDLE);
      avl_address    = AVL_ADDR_WIDTH'({bin_q, rd_idx_q[FRAME_OFFSET_WIDTH-1:0]});
      avl_write      = 1'b0;
      avl_writedata  = '0;
      avl_byteenable = '1;
      noc_data_out   = fifo_valid ? head : '0;
      noc_valid_out  = fifo_valid ? 4'b1111 : 4'b0000;
      noc_sop_out    = (fifo_valid && head_sop) ? 4'b0001 : 4'b0000;
      noc_eop_out    = (fifo_valid && head_eop) ? 4'b1000 : 4'b0000;
   end

   // Frame sequencing: accept request, issue reads, wait for the eop beat to leave
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      len_d      = len_q;
      frame_id_d = frame_id_q;
      rd_idx_d   = rd_idx_q;
      rsp_idx_d  = rsp_idx_q;
      if (rsp_push) begin
         rsp_idx_d = rsp_idx_q + LEN_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (req_valid && (req_len != '0)) begin
               bin_d      = req_bin;
               len_d      = (req_len > MAX_LEN) ? MAX_LEN : req_len;
               frame_id_d = req_frame_id;
               rd_idx_d   = '0;
               rsp_idx_d  = '0;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (rd_accept) begin
               rd_idx_d = rd_idx_q + LEN_W'(1);
               if (rd_idx_q == len_q - LEN_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (fifo_pop && head_eop) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outstanding-read and buffer occupancy bookkeeping
   always_comb begin
      outstanding_d = outstanding_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      case ({rd_accept, rsp_push})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
      case ({rsp_push, fifo_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (rsp_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         bin_q         <= '0;
         len_q         <= '0;
         frame_id_q    <= '0;
         rd_idx_q      <= '0;
         rsp_idx_q     <= '0;
         outstanding_q <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         bin_q         <= bin_d;
         len_q         <= len_d;
         frame_id_q    <= frame_id_d;
         rd_idx_q      <= rd_idx_d;
         rsp_idx_q     <= rsp_idx_d;
         outstanding_q <= outstanding_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // Response buffer storage; contents are only observed through count_q
   always_ff @(posedge clk) begin
      if (rsp_push) begin
         mem_q[wr_ptr_q] <= push_word;
      end
   end

`ifdef DDR_RD_STATS_EN
   logic [31:0] stat_frames_q, stat_frames_d;
   logic [31:0] stat_beats_q, stat_beats_d;

   // Wrapping counters of delivered beats and completed frames
   always_comb begin
      stat_frames_d = stat_frames_q;
      stat_beats_d  = stat_beats_q;
      if (fifo_pop) begin
         stat_beats_d = stat_beats_q + 32'd1;
         if (head_eop) begin
            stat_frames_d = stat_frames_q + 32'd1;
         end
      end
   end

   // Statistics registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_frames_q <= '0;
         stat_beats_q  <= '0;
      end else begin
         stat_frames_q <= stat_frames_d;
         stat_beats_q  <= stat_beats_d;
      end
   end

   assign stat_frames = stat_frames_q;
   assign stat_beats  = stat_beats_q;
`endif

endmodule

// File: tb/tb_pkts_from_ddr_sm.sv
// tb_pkts_from_ddr_sm: DDR read-response model plus NoC scoreboard for pkts_from_ddr_sm.
// Honours DDR_RD_STATS_EN for the optional statistics ports.
module tb_pkts_from_ddr_sm;
   localparam int unsigned AW = 29;
   localparam int unsigned DW = 512;
   localparam int unsigned IW = 32;
   localparam int unsigned BW = 8;
   localparam int unsigned FW = 5;
   localparam int unsigned PW = DW + 2 + IW;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [BW-1:0]     req_bin;
   logic [FW:0]       req_len;
   logic [IW-1:0]     req_frame_id;
   logic [AW-1:0]     avl_address;
   logic              avl_read;
   logic              avl_write;
   logic [DW-1:0]     avl_writedata;
   logic [DW/8-1:0]   avl_byteenable;
   logic              avl_waitrequest;
   logic [DW-1:0]     avl_readdata;
   logic              avl_readdatavalid;
   logic [PW-1:0]     noc_data_out;
   logic [3:0]        noc_valid_out;
   logic [3:0]        noc_sop_out;
   logic [3:0]        noc_eop_out;
   logic              noc_ready_in;
`ifdef DDR_RD_STATS_EN
   logic [31:0]       stat_frames;
   logic [31:0]       stat_beats;
`endif

   pkts_from_ddr_sm #(
      .AVL_ADDR_WIDTH     (AW),
      .AVL_DATA_WIDTH     (DW),
      .FRAME_ID_WIDTH     (IW),
      .BIN_ADDR_WIDTH     (BW),
      .FRAME_OFFSET_WIDTH (FW),
      .RSP_FIFO_DEPTH     (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_bin           (req_bin),
      .req_len           (req_len),
      .req_frame_id      (req_frame_id),
      .avl_address       (avl_address),
      .avl_read          (avl_read),
      .avl_write         (avl_write),
      .avl_writedata     (avl_writedata),
      .avl_byteenable    (avl_byteenable),
      .avl_waitrequest   (avl_waitrequest),
      .avl_readdata      (avl_readdata),
      .avl_readdatavalid (avl_readdatavalid),
      .noc_data_out      (noc_data_out),
      .noc_valid_out     (noc_valid_out),
      .noc_sop_out       (noc_sop_out),
      .noc_eop_out       (noc_eop_out),
      .noc_ready_in      (noc_ready_in)
`ifdef DDR_RD_STATS_EN
      ,
      .stat_frames       (stat_frames),
      .stat_beats        (stat_beats)
`endif
   );

   typedef struct {
      logic [BW-1:0] bin;
      logic [FW:0]   len;
      logic [IW-1:0] id;
      int            beats;
      bit            rand_rdy;
   } vec_t;

   typedef struct {
      logic [PW-1:0] pkt;
      logic [3:0]    sop;
      logic [3:0]    eop;
   } exp_t;

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
   } rsp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   rsp_t          rsp_q[$];

   int errors = 0;
   int checks = 0;
   int rd_count = 0;
   int beat_cnt = 0;
   int stall_at = -1;
   int stall_left = 0;
   bit stray_mode = 1'b0;
   bit rdy_rand_en = 1'b0;

   function automatic void check(input string name, input logic [PW-1:0] act,
                                 input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void fail(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: got %s expected completion", name, what);
   endfunction

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] w;
      w = 32'(a) ^ 32'hA5A5_0000;
      return {16{w}};
   endfunction

   // Expected reads and packet beats for one frame, straight from the frame description
   function automatic void push_expect(input logic [BW-1:0] bin, input logic [IW-1:0] id,
                                       input int beats);
      exp_t          e;
      logic [AW-1:0] a;
      logic [FW-1:0] bi;
      for (int b = 0; b < beats; b++) begin
         bi    = FW'(b);
         a     = AW'({bin, bi});
         exp_addr_q.push_back(a);
         e.pkt = {id, (b == 0), (b == beats - 1), mem_word(a)};
         e.sop = (b == 0) ? 4'b0001 : 4'b0000;
         e.eop = (b == beats - 1) ? 4'b1000 : 4'b0000;
         exp_q.push_back(e);
      end
   endfunction

   initial forever #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Random backpressure, applied 2 time units after the edge
   initial forever begin
      @(posedge clk);
      #2;
      if (rdy_rand_en) noc_ready_in = 1'($urandom_range(0, 1));
   end

   // DDR model (2-cycle read latency, optional waitrequest stall) and NoC monitor
   initial begin
      int            cyc;
      bit            lat_pend;
      bit            held;
      logic [PW-1:0] held_data;
      exp_t          e;
      rsp_t          r;
      cyc      = 0;
      lat_pend = 1'b0;
      held     = 1'b0;
      avl_waitrequest   = 1'b0;
      avl_readdatavalid = 1'b0;
      avl_readdata      = '0;
      forever begin
         @(negedge clk);
         if (lat_pend) begin
            if (stray_mode) check("stray_rsp_ignored", PW'(noc_valid_out), PW'(4'h0));
            else            check("rsp_to_valid_latency", PW'(noc_valid_out), PW'(4'hF));
            lat_pend = 1'b0;
         end
         if (held) begin
            check("hold_valid", PW'(noc_valid_out), PW'(4'hF));
            check("hold_data", noc_data_out, held_data);
         end
         held = 1'b0;
         if (noc_valid_out != 4'h0) begin
            if (noc_ready_in) begin
               if (exp_q.size() == 0) begin
                  fail("unexpected_beat", $sformatf("beat %0h", noc_data_out[31:0]));
               end else begin
                  e = exp_q.pop_front();
                  check("noc_data", noc_data_out, e.pkt);
                  check("noc_sop", PW'(noc_sop_out), PW'(e.sop));
                  check("noc_eop", PW'(noc_eop_out), PW'(e.eop));
                  beat_cnt++;
               end
            end else begin
               held      = 1'b1;
               held_data = noc_data_out;
            end
         end
         if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            avl_readdatavalid = 1'b1;
            avl_readdata      = mem_word(r.addr);
            lat_pend          = 1'b1;
         end else begin
            avl_readdatavalid = 1'b0;
            avl_readdata      = '0;
         end
         avl_waitrequest = 1'b0;
         if (avl_read) begin
            if (rd_count == stall_at && stall_left > 0) begin
               avl_waitrequest = 1'b1;
               stall_left--;
               if (exp_addr_q.size() == 0) fail("stall_addr", "no expected read");
               else check("stall_addr_held", PW'(avl_address), PW'(exp_addr_q[0]));
            end else begin
               rd_count++;
               if (exp_addr_q.size() == 0) begin
                  fail("unexpected_read", $sformatf("addr %0h", avl_address));
               end else begin
                  check("avl_address", PW'(avl_address), PW'(exp_addr_q.pop_front()));
               end
               rsp_q.push_back('{due: cyc + 2, addr: avl_address});
            end
         end
         cyc++;
      end
   end

   // Present a request at posedge+1 and wait for its acceptance; req_valid stays high
   task automatic send_req(input logic [BW-1:0] bin, input logic [FW:0] len,
                           input logic [IW-1:0] id, input int beats);
      int n;
      n            = 0;
      req_valid    = 1'b1;
      req_bin      = bin;
      req_len      = len;
      req_frame_id = id;
      while (!req_ready && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         fail("req_accept", "req_ready stuck low");
         req_valid = 1'b0;
         return;
      end
      push_expect(bin, id, beats);
      @(posedge clk);
      #1;
      if (beats > 0) begin
         check("busy_after_accept", PW'(req_ready), PW'(1'b0));
         check("read_next_cycle", PW'(avl_read), PW'(1'b1));
      end else begin
         check("len0_stays_idle", PW'(req_ready), PW'(1'b1));
         check("len0_no_read", PW'(avl_read), PW'(1'b0));
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n         = 0;
      req_valid = 1'b0;
      while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 3000) begin
         fail(name, $sformatf("timeout with %0d beats pending", exp_q.size()));
         exp_q.delete();
         exp_addr_q.delete();
      end
      check("all_reads_seen", PW'(exp_addr_q.size()), PW'(0));
   endtask

   initial begin
      vec_t vecs[6];
      int   b0;
      int   base;
`ifdef DDR_RD_STATS_EN
      logic [31:0] sf0;
      logic [31:0] sb0;
`endif
      vecs[0] = '{bin: 8'h03, len: 6'd4,  id: 32'h0000_000A, beats: 4,  rand_rdy: 1'b0};
      vecs[1] = '{bin: 8'h15, len: 6'd1,  id: 32'h0000_1234, beats: 1,  rand_rdy: 1'b0};
      vecs[2] = '{bin: 8'hFF, len: 6'd63, id: 32'hDEAD_BEEF, beats: 32, rand_rdy: 1'b0};
      vecs[3] = '{bin: 8'h09, len: 6'd0,  id: 32'h0000_0077, beats: 0,  rand_rdy: 1'b0};
      vecs[4] = '{bin: 8'h80, len: 6'd33, id: 32'h0000_0005, beats: 32, rand_rdy: 1'b1};
      vecs[5] = '{bin: 8'h42, len: 6'd7,  id: 32'h0000_CAFE, beats: 7,  rand_rdy: 1'b1};

      rst          = 1'b1;
      req_valid    = 1'b0;
      req_bin      = '0;
      req_len      = '0;
      req_frame_id = '0;
      noc_ready_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", PW'(req_ready), PW'(1'b1));
      check("rst_avl_read", PW'(avl_read), PW'(1'b0));
      check("rst_avl_write", PW'(avl_write), PW'(1'b0));
      check("rst_writedata", PW'(avl_writedata), PW'(0));
      check("rst_byteenable", PW'(avl_byteenable), PW'({(DW/8){1'b1}}));
      check("rst_address", PW'(avl_address), PW'(0));
      check("rst_noc_valid", PW'(noc_valid_out), PW'(0));
      check("rst_noc_data", noc_data_out, PW'(0));
`ifdef DDR_RD_STATS_EN
      check("rst_stat_frames", PW'(stat_frames), PW'(0));
      check("rst_stat_beats", PW'(stat_beats), PW'(0));
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         rdy_rand_en = vecs[i].rand_rdy;
         if (!vecs[i].rand_rdy) noc_ready_in = 1'b1;
         b0 = beat_cnt;
         send_req(vecs[i].bin, vecs[i].len, vecs[i].id, vecs[i].beats);
         wait_done($sformatf("vec%0d_done", i));
         check($sformatf("vec%0d_beats", i), PW'(beat_cnt - b0), PW'(vecs[i].beats));
      end
      rdy_rand_en  = 1'b0;
      noc_ready_in = 1'b1;
      @(posedge clk);
      #1;

      // Long frame with the NoC blocked: only the buffer depth of reads may go out
      noc_ready_in = 1'b0;
      base         = rd_count;
      send_req(8'h21, 6'd32, 32'h0000_0031, 32);
      req_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("blocked_reads", PW'(rd_count - base), PW'(8));
      check("blocked_no_read", PW'(avl_read), PW'(1'b0));
      noc_ready_in = 1'b1;
      wait_done("blocked_done");

      // waitrequest held for 5 cycles on the second read of a frame
      stall_at   = rd_count + 1;
      stall_left = 5;
      send_req(8'h0C, 6'd4, 32'h0000_0032, 4);
      wait_done("stall_done");
      check("stall_cycles_used", PW'(stall_left), PW'(0));
      stall_at = -1;

      // Zero-length request followed back-to-back by a 2-beat frame
`ifdef DDR_RD_STATS_EN
      sf0 = stat_frames;
      sb0 = stat_beats;
`endif
      b0 = beat_cnt;
      send_req(8'h09, 6'd0, 32'h0000_0033, 0);
      send_req(8'h80, 6'd2, 32'h0000_0034, 2);
      wait_done("b2b_done");
      check("b2b_beats", PW'(beat_cnt - b0), PW'(2));
`ifdef DDR_RD_STATS_EN
      check("stat_frames_delta", PW'(stat_frames - sf0), PW'(1));
      check("stat_beats_delta", PW'(stat_beats - sb0), PW'(2));
`endif

      // Reset after two reads of a 6-beat frame; late responses must vanish
      base = rd_count;
      send_req(8'h05, 6'd6, 32'h0000_0066, 6);
      req_valid = 1'b0;
      while (rd_count < base + 2) @(posedge clk);
      #1;
      rst        = 1'b1;
      stray_mode = 1'b1;
      exp_q.delete();
      exp_addr_q.delete();
      #1;
      check("midrst_avl_read", PW'(avl_read), PW'(1'b0));
      check("midrst_req_ready", PW'(req_ready), PW'(1'b1));
      check("midrst_noc_valid", PW'(noc_valid_out), PW'(0));
      check("midrst_address", PW'(avl_address), PW'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("midrst_rsp_drained", PW'(rsp_q.size()), PW'(0));
      stray_mode = 1'b0;
      b0 = beat_cnt;
      send_req(8'h11, 6'd3, 32'h0000_0077, 3);
      wait_done("post_rst_done");
      check("post_rst_beats", PW'(beat_cnt - b0), PW'(3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
